// File: rtl/jtag_tap_ctrl_if.sv
// rtl/jtag_tap_ctrl_if.sv - TAP serial pins plus the user data register control bundle
interface jtag_tap_ctrl_if #(
    parameter int IR_LENGTH = 4
);
    logic                 TMS;
    logic                 TDI;
    logic                 DR_TDO;
    logic                 TDO;
    logic                 TDO_EN;
    logic                 tdr_select;
    logic                 Capture_DR;
    logic                 Shift_DR;
    logic                 Update_DR;
    logic [IR_LENGTH-1:0] IR_OUT;
    logic [3:0]           TAP_STATE;

    modport master (
        output TMS, TDI, DR_TDO,
        input  TDO, TDO_EN, tdr_select, Capture_DR, Shift_DR, Update_DR, IR_OUT, TAP_STATE
    );

    modport slave (
        input  TMS, TDI, DR_TDO,
        output TDO, TDO_EN, tdr_select, Capture_DR, Shift_DR, Update_DR, IR_OUT, TAP_STATE
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - 1149.1 TAP FSM with IR, BYPASS, IDCODE and user DR strobes
module jtag_tap_ctrl #(
    parameter int                   IR_LENGTH     = 4,
    parameter logic [31:0]          IDCODE_VALUE  = 32'h1000_0001,
    parameter logic [IR_LENGTH-1:0] INSTR_IDCODE  = 4'b0001,
    parameter logic [IR_LENGTH-1:0] INSTR_USER_DR = 4'b0010,
    parameter logic [IR_LENGTH-1:0] INSTR_BYPASS  = 4'b1111
) (
    input  logic            TCK,
    input  logic            TRST_n,
    jtag_tap_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    tap_state_e           state_q, state_d;
    logic [IR_LENGTH-1:0] ir_q, ir_d;
    logic [IR_LENGTH-1:0] ir_sr_q, ir_sr_d;
    logic [31:0]          idcode_sr_q, idcode_sr_d;
    logic                 bypass_q, bypass_d;

    logic sel_idcode;
    logic sel_user;

    // BYPASS is the fallback for INSTR_BYPASS and every undefined opcode.
    assign sel_idcode = (ir_q == INSTR_IDCODE);
    assign sel_user   = (ir_q == INSTR_USER_DR);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = bus.TMS ? TLR      : RTI;
            RTI:      state_d = bus.TMS ? SEL_DR   : RTI;
            SEL_DR:   state_d = bus.TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = bus.TMS ? EX1_DR   : SH_DR;
            SH_DR:    state_d = bus.TMS ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = bus.TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = bus.TMS ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = bus.TMS ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = bus.TMS ? SEL_DR   : RTI;
            SEL_IR:   state_d = bus.TMS ? TLR      : CAP_IR;
            CAP_IR:   state_d = bus.TMS ? EX1_IR   : SH_IR;
            SH_IR:    state_d = bus.TMS ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = bus.TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = bus.TMS ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = bus.TMS ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = bus.TMS ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        idcode_sr_d = idcode_sr_q;
        bypass_d    = bypass_q;
        case (state_q)
            CAP_IR: ir_sr_d = {{(IR_LENGTH-2){1'b0}}, 2'b01};
            SH_IR:  ir_sr_d = {ir_sr_q[IR_LENGTH-2:0], bus.TDI};
            UPD_IR: ir_d    = ir_sr_q;
            CAP_DR: begin
                if (sel_idcode)
                    idcode_sr_d = IDCODE_VALUE;
                else if (!sel_user)
                    bypass_d = 1'b0;
            end
            SH_DR: begin
                if (sel_idcode)
                    idcode_sr_d = {idcode_sr_q[30:0], bus.TDI};
                else if (!sel_user)
                    bypass_d = bus.TDI;
            end
            default: ;
        endcase
        // Landing in TLR by TMS must already present IDCODE as the instruction.
        if (state_d == TLR)
            ir_d = INSTR_IDCODE;
    end

    always_ff @(posedge TCK) begin
        if (!TRST_n) begin
            state_q     <= TLR;
            ir_q        <= INSTR_IDCODE;
            ir_sr_q     <= '0;
            idcode_sr_q <= IDCODE_VALUE;
            bypass_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            idcode_sr_q <= idcode_sr_d;
            bypass_q    <= bypass_d;
        end
    end

    always_comb begin
        bus.TDO = 1'b0;
        if (state_q == SH_IR)
            bus.TDO = ir_sr_q[IR_LENGTH-1];
        else if (state_q == SH_DR)
            bus.TDO = sel_user ? bus.DR_TDO : (sel_idcode ? idcode_sr_q[31] : bypass_q);
    end

    assign bus.TDO_EN     = (state_q == SH_IR) || (state_q == SH_DR);
    assign bus.tdr_select = sel_user;
    assign bus.Capture_DR = (state_q == CAP_DR);
    assign bus.Shift_DR   = (state_q == SH_DR);
    assign bus.Update_DR  = (state_q == UPD_DR);
    assign bus.IR_OUT     = ir_q;
    assign bus.TAP_STATE  = state_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - scoreboard bench for jtag_tap_ctrl
module tb_jtag_tap_ctrl;

    logic tck = 1'b0;
    logic trst_n = 1'b0;

    jtag_tap_ctrl_if #(.IR_LENGTH(4)) bus ();

    jtag_tap_ctrl dut (
        .TCK    (tck),
        .TRST_n (trst_n),
        .bus    (bus)
    );

    always #5 tck = ~tck;

    int n_checks = 0;
    int n_errors = 0;

    logic tdo_q[$];
    int   cap_cnt = 0;
    int   sh_cnt = 0;
    int   upd_cnt = 0;
    int   upd_ir_cnt = 0;

    logic [7:0] user_q = 8'h00;
    logic [7:0] user_upd = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // User data register model: captures A5, shifts on Shift_DR, latches on Update_DR.
    always @(posedge tck) begin
        if (bus.tdr_select && bus.Capture_DR)
            user_q <= 8'hA5;
        else if (bus.tdr_select && bus.Shift_DR)
            user_q <= {user_q[6:0], bus.TDI};
        if (bus.tdr_select && bus.Update_DR)
            user_upd <= user_q;
    end
    assign bus.DR_TDO = user_q[7];

    always @(negedge tck) begin
        if (bus.Capture_DR) cap_cnt = cap_cnt + 1;
        if (bus.Shift_DR)   sh_cnt  = sh_cnt + 1;
        if (bus.Update_DR)  upd_cnt = upd_cnt + 1;
        if (bus.TAP_STATE == 4'hD) upd_ir_cnt = upd_ir_cnt + 1;
        if (bus.TDO_EN && tdo_q.size() > 0)
            check("tdo", {31'b0, bus.TDO}, {31'b0, tdo_q.pop_front()});
    end

    task automatic tick(input logic tms, input logic tdi);
        bus.TMS = tms;
        bus.TDI = tdi;
        @(posedge tck);
        #1;
    endtask

    // From RTI: capture/shift/update IR, ending back in RTI.
    task automatic load_ir(input logic [3:0] v);
        tdo_q.push_back(1'b0); tdo_q.push_back(1'b0);
        tdo_q.push_back(1'b0); tdo_q.push_back(1'b1);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 3; i >= 0; i--) tick(i == 0, v[i]);
        tick(1, 0);
        tick(0, 0);
        check("ir_drain", tdo_q.size(), 0);
        check("ir_out", {28'b0, bus.IR_OUT}, {28'b0, v});
    endtask

    // From RTI: capture, shift n bits (din[0] first), update, back to RTI.
    task automatic shift_dr(input int n, input logic [31:0] din);
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < n; i++) tick(i == n - 1, din[i]);
        tick(1, 0);
        tick(0, 0);
        check("dr_drain", tdo_q.size(), 0);
    endtask

    logic       walk_tms [23] = '{1,0,0,1,0,1,0,1,0,1,1,1,1,0,1,0,1,0,1,1,1,1,1};
    logic [3:0] walk_st  [23] = '{4'hF,4'hC,4'hC,4'h7,4'h6,4'h1,4'h3,4'h0,4'h2,4'h1,4'h5,4'h7,
                                  4'h4,4'hE,4'h9,4'hB,4'h8,4'hA,4'h9,4'hD,4'h7,4'h4,4'hF};
    logic [31:0] idv = 32'h1000_0001;

    initial begin
        bus.TMS = 1'b1;
        bus.TDI = 1'b0;
        trst_n  = 1'b0;
        @(posedge tck); @(posedge tck); #1;
        trst_n = 1'b1;
        check("rst_state", {28'b0, bus.TAP_STATE}, 32'hF);
        check("rst_ir", {28'b0, bus.IR_OUT}, 32'h1);
        check("rst_tdo", {31'b0, bus.TDO}, 0);
        check("rst_tdo_en", {31'b0, bus.TDO_EN}, 0);
        check("rst_tdr_sel", {31'b0, bus.tdr_select}, 0);
        check("rst_strobes", {29'b0, bus.Capture_DR, bus.Shift_DR, bus.Update_DR}, 0);

        for (int i = 0; i < 23; i++) begin
            tick(walk_tms[i], 1'b0);
            check($sformatf("walk_%0d", i), {28'b0, bus.TAP_STATE}, {28'b0, walk_st[i]});
        end
        check("walk_ir", {28'b0, bus.IR_OUT}, 32'h1);

        tick(0, 0);
        for (int i = 31; i >= 0; i--) tdo_q.push_back(idv[i]);
        shift_dr(32, 32'h0);
        check("idcode_tdr_sel", {31'b0, bus.tdr_select}, 0);

        load_ir(4'b0010);
        check("user_tdr_sel", {31'b0, bus.tdr_select}, 1);

        cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
        tdo_q.push_back(1'b1); tdo_q.push_back(1'b0); tdo_q.push_back(1'b1);
        tdo_q.push_back(1'b0); tdo_q.push_back(1'b0);
        shift_dr(5, 32'b10011);
        check("cap_cnt", cap_cnt, 1);
        check("sh_cnt", sh_cnt, 5);
        check("upd_cnt", upd_cnt, 1);
        check("user_upd", {24'b0, user_upd}, 32'hB9);

        load_ir(4'b1111);
        check("byp_tdr_sel", {31'b0, bus.tdr_select}, 0);
        tdo_q.push_back(1'b0); tdo_q.push_back(1'b1);
        tdo_q.push_back(1'b0); tdo_q.push_back(1'b1);
        shift_dr(4, 32'b1101);

        load_ir(4'b0110);
        tdo_q.push_back(1'b0); tdo_q.push_back(1'b1);
        tdo_q.push_back(1'b0); tdo_q.push_back(1'b1);
        shift_dr(4, 32'b1101);

        load_ir(4'b0010);
        tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
        check("pause_state", {28'b0, bus.TAP_STATE}, 32'h3);
        for (int i = 0; i < 5; i++) tick(1, 0);
        check("tms_rst_state", {28'b0, bus.TAP_STATE}, 32'hF);
        check("tms_rst_ir", {28'b0, bus.IR_OUT}, 32'h1);
        check("tms_rst_tdr_sel", {31'b0, bus.tdr_select}, 0);

        tick(0, 0);
        load_ir(4'b0010);
        upd_ir_cnt = 0;
        tdo_q.push_back(1'b0); tdo_q.push_back(1'b0); tdo_q.push_back(1'b0);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        tick(0, 1); tick(0, 1);
        check("mid_state", {28'b0, bus.TAP_STATE}, 32'hA);
        trst_n = 1'b0;
        tick(0, 1);
        trst_n = 1'b1;
        check("mid_rst_state", {28'b0, bus.TAP_STATE}, 32'hF);
        check("mid_rst_ir", {28'b0, bus.IR_OUT}, 32'h1);
        check("mid_rst_tdo_en", {31'b0, bus.TDO_EN}, 0);
        check("mid_rst_tdo", {31'b0, bus.TDO}, 0);
        check("mid_rst_drain", tdo_q.size(), 0);
        tick(1, 0);
        check("mid_rst_no_updir", upd_ir_cnt, 0);
        check("mid_rst_hold_ir", {28'b0, bus.IR_OUT}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
